// File: rtl/adc_scan_arbiter.sv
// Round-robin arbiter sharing one ADC conversion engine between NREQ requesters,
// with a minimum start-to-start interval and a conversion timeout.
module adc_scan_arbiter #(
  parameter int NREQ        = 4,
  parameter int CLK_RATE    = 50000000,
  parameter int ADC_RATE    = 48000,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_ch,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [11:0]       data,
  output logic              err,
  output logic              busy,
  output logic              adc_start,
  output logic [2:0]        adc_ch,
  input  logic              adc_ready,
  input  logic              adc_done,
  input  logic [11:0]       adc_data
);

  localparam int MIN_GAP = CLK_RATE / ADC_RATE;
  localparam int MAX_CNT = (MIN_GAP > TIMEOUT_CYC) ? MIN_GAP : TIMEOUT_CYC;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int PW      = $clog2(NREQ);

  localparam logic [CW-1:0]   CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0]   GAP_LIM  = CW'(MIN_GAP);
  localparam logic [CW-1:0]   TO_LIM   = CW'(TIMEOUT_CYC);
  localparam logic [PW:0]     SUM_N    = (PW + 1)'(NREQ);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [CW-1:0]   r_gap_cnt;
  logic [CW-1:0]   r_to_cnt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] r_done;
  logic [11:0]     r_data;
  logic            r_err;
  logic            r_busy;
  logic            r_adc_start;
  logic [2:0]      r_adc_ch;

  logic [NREQ-1:0] w_req_rot;
  logic [PW-1:0]   w_off;
  logic [PW:0]     w_sum;
  logic [PW-1:0]   w_win;
  logic [5:0]      w_ch_sh_amt;
  logic [2:0]      w_win_ch;
  logic [PW-1:0]   w_ptr_nxt;
  logic            w_start;
  logic            w_finish;
  logic            w_fin_err;

  // Lowest set bit of a request vector already rotated so bit 0 is the pointer position.
  function automatic logic [PW-1:0] first_set(input logic [NREQ-1:0] v);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  // Reset synchroniser: asserts asynchronously, releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Round-robin winner search, channel select and next pointer.
  always_comb begin
    w_req_rot   = NREQ'({req, req} >> r_ptr);
    w_off       = first_set(w_req_rot);
    w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= SUM_N) w_win = PW'(w_sum - SUM_N);
    else                w_win = w_sum[PW-1:0];
    w_ch_sh_amt = 6'(w_win) * 6'd3;
    w_win_ch    = 3'(req_ch >> w_ch_sh_amt);
    if (r_owner == LAST_IDX) w_ptr_nxt = '0;
    else                     w_ptr_nxt = r_owner + PW'(1);
  end

  // Next-state decode and one-cycle start/finish events.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    w_fin_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((|req) && adc_ready) begin
          w_state_nxt = ST_WAIT;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A result arriving on the expiry cycle still counts as a good conversion.
        if (adc_done) begin
          w_state_nxt = ST_GAP;
          w_finish    = 1'b1;
        end else if (r_to_cnt >= TO_LIM) begin
          w_state_nxt = ST_GAP;
          w_finish    = 1'b1;
          w_fin_err   = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt >= GAP_LIM) w_state_nxt = ST_IDLE;
        else                      w_state_nxt = ST_GAP;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Registered outputs, owner/pointer bookkeeping and saturating counters.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ptr       <= '0;
      r_owner     <= '0;
      r_gap_cnt   <= '0;
      r_to_cnt    <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_data      <= 12'd0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_adc_start <= 1'b0;
      r_adc_ch    <= 3'd0;
    end else begin
      r_adc_start <= w_start;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= '0;
      if (w_start) begin
        r_gap_cnt <= '0;
        r_to_cnt  <= '0;
        r_owner   <= w_win;
        r_grant   <= ONE_HOT0 << w_win;
        r_adc_ch  <= w_win_ch;
      end else begin
        if (r_gap_cnt != CNT_SAT) r_gap_cnt <= r_gap_cnt + CW'(1);
        if (r_to_cnt  != CNT_SAT) r_to_cnt  <= r_to_cnt + CW'(1);
      end
      if (w_finish) begin
        r_done  <= ONE_HOT0 << r_owner;
        r_grant <= '0;
        r_data  <= w_fin_err ? 12'd0 : adc_data;
        r_err   <= w_fin_err;
        r_ptr   <= w_ptr_nxt;
      end
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign data      = r_data;
  assign err       = r_err;
  assign busy      = r_busy;
  assign adc_start = r_adc_start;
  assign adc_ch    = r_adc_ch;

endmodule

// File: tb/tb_adc_scan_arbiter.sv
// Self-checking bench for adc_scan_arbiter: table of single conversions plus
// hand-written round-robin, drop, ready, reset and timeout-coincidence sequences.
module tb_adc_scan_arbiter;

  localparam int NREQ    = 4;
  localparam int MIN_GAP = 1041;
  localparam int TO_CYC  = 4096;
  localparam logic [11:0] CHS = 12'hC55;  // ch3=6 ch2=1 ch1=2 ch0=5

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [11:0] req_ch;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [11:0] data;
  logic        err;
  logic        busy;
  logic        adc_start;
  logic [2:0]  adc_ch;
  logic        adc_ready;
  logic        adc_done;
  logic [11:0] adc_data;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] req_ch;
    int          lat;
    logic [11:0] adata;
    logic [3:0]  exp_grant;
    logic [2:0]  exp_ch;
    logic [11:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   last_start = -1;

  adc_scan_arbiter #(
    .NREQ(4), .CLK_RATE(50000000), .ADC_RATE(48000), .TIMEOUT_CYC(4096)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_ch(req_ch),
    .grant(grant), .done(done), .data(data), .err(err), .busy(busy),
    .adc_start(adc_start), .adc_ch(adc_ch), .adc_ready(adc_ready),
    .adc_done(adc_done), .adc_data(adc_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: got bound expired, expected event", nm);
  endtask

  task automatic note_start(input string nm);
    if (last_start >= 0)
      chk({nm, "_spacing_ge_min_gap"}, (cyc - last_start >= MIN_GAP) ? 32'd1 : 32'd0, 32'd1);
    last_start = cyc;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) fail_now({nm, "_wait_idle"});
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (adc_start !== 1'b1 && n < 3000);
    if (adc_start !== 1'b1) fail_now({nm, "_wait_start"});
    else note_start(nm);
  endtask

  // Called on the start cycle; plays the engine and checks the done cycle.
  task automatic finish_conv(input logic [3:0] owner, input int lat, input logic [11:0] adat,
                             input logic [11:0] exp_data, input logic exp_err,
                             input int drop_at, input logic [3:0] drop_val, input string nm);
    logic early;
    int   n;
    early = 1'b0;
    n     = 0;
    if (lat < 0) begin
      do begin
        @(negedge clk);
        n++;
      end while (done === 4'b0000 && n < 6000);
      chk({nm, "_timeout_cycles"}, n, TO_CYC + 1);
    end else begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        if (done !== 4'b0000) early = 1'b1;
        if (k == drop_at) req = drop_val;
      end
      chk({nm, "_no_early_done"}, early, 1'b0);
      chk({nm, "_grant_held"}, grant, owner);
      adc_done = 1'b1;
      adc_data = adat;
      @(negedge clk);
      adc_done = 1'b0;
      adc_data = ~adat;
    end
    chk({nm, "_done"}, done, owner);
    chk({nm, "_data"}, data, exp_data);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_grant_cleared"}, grant, 4'b0000);
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, done, 4'b0000);
    chk({nm, "_data_held"}, data, exp_data);
  endtask

  task automatic run_conv(input vec_t v, input string nm);
    wait_idle(nm);
    req    = v.req;
    req_ch = v.req_ch;
    @(negedge clk);
    chk({nm, "_start_1_after_req"}, adc_start, 1'b1);
    if (adc_start === 1'b1) note_start(nm);
    chk({nm, "_grant"}, grant, v.exp_grant);
    chk({nm, "_adc_ch"}, adc_ch, v.exp_ch);
    chk({nm, "_busy"}, busy, 1'b1);
    finish_conv(v.exp_grant, v.lat, v.adata, v.exp_data, v.exp_err, -1, 4'b0000, nm);
    req = 4'b0000;
  endtask

  initial begin
    logic [3:0]  ord_a [5];
    logic [2:0]  ch_a  [5];
    logic [3:0]  ord_d [4];
    int          lat_d [4];
    logic        bad;
    vec_t        vb;

    vecs[0] = '{4'b0001, 12'h005, 40,  12'hABC, 4'b0001, 3'd5, 12'hABC, 1'b0};
    vecs[1] = '{4'b0110, 12'h198, 10,  12'h123, 4'b0010, 3'd3, 12'h123, 1'b0};
    vecs[2] = '{4'b1001, 12'hE01, 1,   12'hFFF, 4'b1000, 3'd7, 12'hFFF, 1'b0};
    vecs[3] = '{4'b1110, 12'h310, 100, 12'h5A5, 4'b0010, 3'd2, 12'h5A5, 1'b0};
    vecs[4] = '{4'b0011, 12'h03C, 3,   12'h800, 4'b0001, 3'd4, 12'h800, 1'b0};
    vecs[5] = '{4'b0001, 12'hFF8, 2,   12'h001, 4'b0001, 3'd0, 12'h001, 1'b0};
    vecs[6] = '{4'b0100, 12'h043, -1,  12'h000, 4'b0100, 3'd1, 12'h000, 1'b1};
    vecs[7] = '{4'b1001, 12'hC02, 20,  12'h7E7, 4'b1000, 3'd6, 12'h7E7, 1'b0};
    ord_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ch_a  = '{3'd5, 3'd2, 3'd1, 3'd6, 3'd5};
    ord_d = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    lat_d = '{15, 15, 15, TO_CYC};

    reset_n   = 1'b0;
    req       = 4'b0000;
    req_ch    = 12'h000;
    adc_ready = 1'b1;
    adc_done  = 1'b0;
    adc_data  = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_data", data, 12'h000);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_adc_start", adc_start, 1'b0);
    chk("rst_adc_ch", adc_ch, 3'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_req_busy", busy, 1'b0);

    for (int i = 0; i < 8; i++) run_conv(vecs[i], $sformatf("vec%0d", i));

    // All four requesters held: strict rotation starting from pointer 0.
    wait_idle("rr");
    req    = 4'b1111;
    req_ch = CHS;
    for (int i = 0; i < 5; i++) begin
      wait_start($sformatf("rr%0d", i));
      chk($sformatf("rr%0d_grant", i), grant, ord_a[i]);
      chk($sformatf("rr%0d_adc_ch", i), adc_ch, ch_a[i]);
      finish_conv(ord_a[i], 30, 12'h100 + 12'(i), 12'h100 + 12'(i), 1'b0, -1, 4'b0000,
                  $sformatf("rr%0d", i));
    end
    req = 4'b0000;

    // Owner drops its request mid-conversion; the result is still delivered.
    vb = '{4'b0010, CHS, 8, 12'h246, 4'b0010, 3'd2, 12'h246, 1'b0};
    run_conv(vb, "pre_drop");
    wait_idle("drop");
    req = 4'b0011;
    @(negedge clk);
    chk("drop_start", adc_start, 1'b1);
    if (adc_start === 1'b1) note_start("drop");
    chk("drop_grant", grant, 4'b0001);
    finish_conv(4'b0001, 25, 12'h321, 12'h321, 1'b0, 10, 4'b0010, "drop");
    wait_start("drop_next");
    chk("drop_next_grant", grant, 4'b0010);
    finish_conv(4'b0010, 5, 12'h654, 12'h654, 1'b0, -1, 4'b0000, "drop_next");
    req = 4'b0000;

    // Engine not ready holds off the start; then reset mid-conversion.
    wait_idle("rdy");
    adc_ready = 1'b0;
    req       = 4'b0100;
    bad       = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (adc_start !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("rdy_low_no_start", bad, 1'b0);
    adc_ready = 1'b1;
    @(negedge clk);
    chk("rdy_rise_start", adc_start, 1'b1);
    chk("rdy_grant", grant, 4'b0100);
    chk("rdy_adc_ch", adc_ch, 3'd1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_grant", grant, 4'b0000);
    chk("midrst_busy", busy, 1'b0);
    req = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    adc_done = 1'b1;
    adc_data = 12'h9C3;
    @(negedge clk);
    adc_done = 1'b0;
    bad      = 1'b0;
    repeat (3) begin
      if (done !== 4'b0000) bad = 1'b1;
      @(negedge clk);
    end
    chk("stray_done_ignored", bad, 1'b0);
    chk("stray_data_unchanged", data, 12'h000);
    chk("stray_busy", busy, 1'b0);
    last_start = -1;

    // Requesters 0 and 2 alternate; last result lands exactly on timeout expiry.
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_start($sformatf("alt%0d", i));
      chk($sformatf("alt%0d_grant", i), grant, ord_d[i]);
      finish_conv(ord_d[i], lat_d[i], 12'h3C0 + 12'(i), 12'h3C0 + 12'(i), 1'b0, -1, 4'b0000,
                  $sformatf("alt%0d", i));
    end
    req = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
